// File: rtl/nvme_resp_pkg.sv
// nvme_resp_pkg: shared CQE layout, FSM state encodings and queue entry sizes
package nvme_resp_pkg;
  localparam int SQE_BYTES = 64;
  localparam int CQE_BYTES = 16;
  localparam int SQE_SH = $clog2(SQE_BYTES);
  localparam int CQE_SH = $clog2(CQE_BYTES);
  typedef struct packed {
    logic [31:0] dw3;
    logic [31:0] dw2;
    logic [31:0] dw1;
    logic [31:0] dw0;
  } cqe_t;
  typedef enum logic [1:0] {F_IDLE, F_AR, F_R, F_CMD} fetch_e;
  typedef enum logic [1:0] {P_IDLE, P_AW, P_B} post_e;
endpackage

// File: rtl/nvme_sq_responder_if.sv
// nvme_sq_responder_if: doorbell, AXI4 read/write, command and completion channels
interface nvme_sq_responder_if;
  logic         sqdb_valid, sqdb_ready;
  logic [15:0]  sqdb_tail;
  logic         cqdb_valid, cqdb_ready;
  logic [15:0]  cqdb_head;
  logic         arvalid, arready;
  logic [63:0]  araddr;
  logic [11:0]  arid;
  logic         rvalid, rready;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic [11:0]  rid;
  logic         rlast;
  logic         awvalid, awready;
  logic [63:0]  awaddr;
  logic [11:0]  awid;
  logic         wvalid, wready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic [11:0]  bid;
  logic         cmd_valid, cmd_ready;
  logic [511:0] cmd_sqe;
  logic         cpl_valid, cpl_ready;
  logic [15:0]  cpl_cid;
  logic [14:0]  cpl_status;
  modport master (
    input  sqdb_valid, sqdb_tail, cqdb_valid, cqdb_head, arready, rvalid, rdata, rresp, rid, rlast,
           awready, wready, bvalid, bresp, bid, cmd_ready, cpl_valid, cpl_cid, cpl_status,
    output sqdb_ready, cqdb_ready, arvalid, araddr, arid, rready, awvalid, awaddr, awid,
           wvalid, wdata, wstrb, wlast, bready, cmd_valid, cmd_sqe, cpl_ready
  );
  modport slave (
    output sqdb_valid, sqdb_tail, cqdb_valid, cqdb_head, arready, rvalid, rdata, rresp, rid, rlast,
           awready, wready, bvalid, bresp, bid, cmd_ready, cpl_valid, cpl_cid, cpl_status,
    input  sqdb_ready, cqdb_ready, arvalid, araddr, arid, rready, awvalid, awaddr, awid,
           wvalid, wdata, wstrb, wlast, bready, cmd_valid, cmd_sqe, cpl_ready
  );
endinterface

// File: rtl/nvme_ring_ptr.sv
// nvme_ring_ptr: power-of-two wrapping ring pointer with phase bit and empty/full compare
module nvme_ring_ptr #(
  parameter int DEPTH = 64,
  localparam int W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] cmp_i,
  output logic [W-1:0] ptr_o,
  output logic         phase_o,
  output logic         empty_o,
  output logic         full_o
);
  logic [W-1:0] ptr_q, ptr_d;
  logic         phase_q, phase_d;
  always_comb begin
    ptr_d = load_i ? load_val_i : inc_i ? W'(ptr_q + 1'b1) : ptr_q;
    phase_d = phase_q ^ (inc_i && !load_i && ptr_q == W'(DEPTH - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      phase_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
      phase_q <= phase_d;
    end
  end
  assign ptr_o = ptr_q;
  assign phase_o = phase_q;
  assign empty_o = ptr_q == cmp_i;
  assign full_o = W'(ptr_q + 1'b1) == cmp_i;
endmodule

// File: rtl/nvme_sq_responder.sv
// nvme_sq_responder: NVMe SQE fetch / CQE post responder; NVME_RESP_RESP_CHECK_EN adds rresp/bresp error checks
module nvme_sq_responder
  import nvme_resp_pkg::*;
#(
  parameter int          QDEPTH  = 64,
  parameter logic [15:0] SQ_ID   = 16'd1,
  parameter logic [11:0] ARID_SQ = 12'h040,
  parameter logic [11:0] AWID_CQ = 12'h040
) (
  input  logic                axi4_mm_clk,
  input  logic                axi4_mm_rst,
  input  logic [63:0]         i_sq_base,
  input  logic [63:0]         i_cq_base,
  nvme_sq_responder_if.master bus,
  output logic [15:0]         o_sq_head,
  output logic [15:0]         o_cq_tail,
  output logic                o_phase,
  output logic                o_err
);
  localparam int W = $clog2(QDEPTH);
  fetch_e       f_q, f_d;
  post_e        p_q, p_d;
  logic         live_q, err_q, err_d, aw_pend_q, w_pend_q;
  logic [W-1:0] sq_tail_q, cq_head_q, sq_ptr, cq_ptr;
  logic [63:0]  araddr_q, awaddr_q, wstrb_q;
  logic [511:0] sqe_q, wdata_q;
  logic [1:0]   lane;
  logic         sq_empty, cq_full, cq_phase, sq_inc, cq_inc;
  logic         sq_db, cq_db, sq_bad, cq_bad, r_hit, r_bad, b_hit, b_bad, cpl_fire;
  logic         unused_sq_phase, unused_sq_full, unused_cq_empty;
  cqe_t         cqe;
  assign sq_db = bus.sqdb_valid && live_q;
  assign cq_db = bus.cqdb_valid && live_q;
  assign sq_bad = bus.sqdb_tail >= 16'(QDEPTH);
  assign cq_bad = bus.cqdb_head >= 16'(QDEPTH);
  assign r_hit = bus.rvalid && bus.rid == ARID_SQ && bus.rlast;
  assign b_hit = bus.bvalid && bus.bid == AWID_CQ;
  assign cpl_fire = bus.cpl_valid && bus.cpl_ready;
  assign lane = 2'(cq_ptr);
`ifdef NVME_RESP_RESP_CHECK_EN
  assign r_bad = bus.rresp != 2'b00;
  assign b_bad = bus.bresp != 2'b00;
`else
  logic unused_resp;
  assign unused_resp = ^{bus.rresp, bus.bresp};
  assign r_bad = 1'b0;
  assign b_bad = 1'b0;
`endif
  assign err_d = err_q | (sq_db & sq_bad) | (cq_db & cq_bad) | (f_q == F_R & r_hit & r_bad) |
                 (p_q == P_B & b_hit & b_bad);
  always_comb begin
    f_d = f_q;
    sq_inc = 1'b0;
    case (f_q)
      F_IDLE: f_d = sq_empty ? F_IDLE : F_AR;
      F_AR:   f_d = bus.arready ? F_R : F_AR;
      F_R: if (r_hit) begin
        f_d = r_bad ? F_IDLE : F_CMD;
        sq_inc = r_bad;
      end
      F_CMD: if (bus.cmd_ready) begin
        f_d = F_IDLE;
        sq_inc = 1'b1;
      end
      default: f_d = F_IDLE;
    endcase
  end
  always_comb begin
    p_d = p_q;
    cq_inc = 1'b0;
    case (p_q)
      P_IDLE: p_d = cpl_fire ? P_AW : P_IDLE;
      P_AW:   p_d = (!aw_pend_q || bus.awready) && (!w_pend_q || bus.wready) ? P_B : P_AW;
      P_B: if (b_hit) begin
        p_d = P_IDLE;
        cq_inc = 1'b1;
      end
      default: p_d = P_IDLE;
    endcase
  end
  always_comb begin
    cqe = '0;
    cqe.dw2 = {SQ_ID, 16'(sq_ptr)};
    cqe.dw3 = {bus.cpl_status, cq_phase, bus.cpl_cid};
  end
  always_ff @(posedge axi4_mm_clk) begin
    if (axi4_mm_rst) begin
      f_q <= F_IDLE;
      p_q <= P_IDLE;
      live_q <= 1'b0;
      err_q <= 1'b0;
      sq_tail_q <= '0;
      cq_head_q <= '0;
      araddr_q <= '0;
      awaddr_q <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      sqe_q <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q <= 1'b0;
    end else begin
      f_q <= f_d;
      p_q <= p_d;
      live_q <= 1'b1;
      err_q <= err_d;
      if (sq_db && !sq_bad) sq_tail_q <= bus.sqdb_tail[W-1:0];
      if (cq_db && !cq_bad) cq_head_q <= bus.cqdb_head[W-1:0];
      if (f_q == F_IDLE && !sq_empty) araddr_q <= i_sq_base + (64'(sq_ptr) << SQE_SH);
      if (f_q == F_R && bus.rvalid && bus.rid == ARID_SQ) sqe_q <= bus.rdata;
      if (cpl_fire) begin
        awaddr_q <= (i_cq_base + (64'(cq_ptr) << CQE_SH)) & ~64'd63;
        wdata_q <= 512'(cqe) << {lane, 7'd0};
        wstrb_q <= 64'hFFFF << {lane, 4'd0};
        aw_pend_q <= 1'b1;
        w_pend_q <= 1'b1;
      end else begin
        if (bus.awready) aw_pend_q <= 1'b0;
        if (bus.wready) w_pend_q <= 1'b0;
      end
    end
  end
  nvme_ring_ptr #(.DEPTH(QDEPTH)) u_sq_head (
    .clk(axi4_mm_clk), .rst(axi4_mm_rst), .inc_i(sq_inc), .load_i(1'b0), .load_val_i('0),
    .cmp_i(sq_tail_q), .ptr_o(sq_ptr), .phase_o(unused_sq_phase), .empty_o(sq_empty),
    .full_o(unused_sq_full)
  );
  nvme_ring_ptr #(.DEPTH(QDEPTH)) u_cq_tail (
    .clk(axi4_mm_clk), .rst(axi4_mm_rst), .inc_i(cq_inc), .load_i(1'b0), .load_val_i('0),
    .cmp_i(cq_head_q), .ptr_o(cq_ptr), .phase_o(cq_phase), .empty_o(unused_cq_empty),
    .full_o(cq_full)
  );
  assign bus.sqdb_ready = live_q;
  assign bus.cqdb_ready = live_q;
  assign bus.arvalid = f_q == F_AR;
  assign bus.araddr = araddr_q;
  assign bus.arid = ARID_SQ;
  assign bus.rready = f_q == F_R;
  assign bus.cmd_valid = f_q == F_CMD;
  assign bus.cmd_sqe = sqe_q;
  assign bus.cpl_ready = live_q && p_q == P_IDLE && !cq_full;
  assign bus.awvalid = aw_pend_q;
  assign bus.awaddr = awaddr_q;
  assign bus.awid = AWID_CQ;
  assign bus.wvalid = w_pend_q;
  assign bus.wdata = wdata_q;
  assign bus.wstrb = wstrb_q;
  assign bus.wlast = w_pend_q;
  assign bus.bready = p_q == P_B;
  assign o_sq_head = 16'(sq_ptr);
  assign o_cq_tail = 16'(cq_ptr);
  assign o_phase = cq_phase;
  assign o_err = err_q;
endmodule

// File: tb/tb_nvme_sq_responder.sv
// tb_nvme_sq_responder: directed checks of SQE fetch, CQE lane/phase, full, doorbell errors and reset
module tb_nvme_sq_responder;
  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  sq_base, cq_base, aa, ws;
  logic [511:0] wd;
  logic [15:0]  sq_head, cq_tail;
  logic         phase, err;
  int           n_chk = 0;
  int           n_err = 0;
  nvme_sq_responder_if bus ();
  nvme_sq_responder dut (
    .axi4_mm_clk(clk), .axi4_mm_rst(rst), .i_sq_base(sq_base), .i_cq_base(cq_base), .bus(bus),
    .o_sq_head(sq_head), .o_cq_tail(cq_tail), .o_phase(phase), .o_err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic clear_in();
    bus.sqdb_valid = 0; bus.sqdb_tail = 0; bus.cqdb_valid = 0; bus.cqdb_head = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = 0; bus.rid = 0; bus.rlast = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.bid = 0;
    bus.cmd_ready = 0; bus.cpl_valid = 0; bus.cpl_cid = 0; bus.cpl_status = 0;
  endtask
  task automatic do_reset();
    rst = 1; clear_in(); tick(); tick(); rst = 0; tick();
  endtask
  task automatic sqdb(input logic [15:0] v);
    bus.sqdb_valid = 1; bus.sqdb_tail = v; tick(); bus.sqdb_valid = 0;
  endtask
  task automatic cqdb(input logic [15:0] v);
    bus.cqdb_valid = 1; bus.cqdb_head = v; tick(); bus.cqdb_valid = 0;
  endtask
  task automatic fetch(input logic [63:0] addr, input logic [511:0] data, input logic [1:0] resp,
                       input bit drop, input bit stray);
    int t = 0;
    while (!bus.arvalid && t < 20) begin tick(); t++; end
    chk("ar_lat", t, 1);
    chk("araddr", bus.araddr, addr);
    chk("arid", bus.arid, 12'h040);
    bus.arready = 1; tick(); bus.arready = 0;
    chk("rready", bus.rready, 1);
    if (stray) begin
      bus.rvalid = 1; bus.rid = 12'h041; bus.rlast = 1; bus.rdata = ~data; tick(); bus.rvalid = 0;
      chk("stray_rid", {bus.cmd_valid, bus.rready}, 2'b01);
    end
    bus.rvalid = 1; bus.rid = 12'h040; bus.rlast = 1; bus.rdata = data; bus.rresp = resp;
    tick(); bus.rvalid = 0; bus.rresp = 0;
    if (drop) chk("cmd_drop", bus.cmd_valid, 0);
    else begin
      chk("cmd_valid", bus.cmd_valid, 1);
      chk("cmd_sqe", bus.cmd_sqe, data);
      bus.cmd_ready = 1; tick(); bus.cmd_ready = 0;
    end
  endtask
  task automatic post(input logic [15:0] cid, input logic [14:0] st, input bit split,
                      output logic [63:0] a, output logic [63:0] s, output logic [511:0] d);
    int t = 0;
    while (!bus.cpl_ready && t < 20) begin tick(); t++; end
    chk("cpl_wait", t < 20, 1);
    bus.cpl_valid = 1; bus.cpl_cid = cid; bus.cpl_status = st; tick(); bus.cpl_valid = 0;
    chk("aw_w_valid", {bus.awvalid, bus.wvalid, bus.wlast, bus.cpl_ready}, 4'b1110);
    chk("awid", bus.awid, 12'h040);
    a = bus.awaddr; s = bus.wstrb; d = bus.wdata;
    if (split) begin
      bus.awready = 1; tick(); bus.awready = 0;
      chk("aw_only", {bus.awvalid, bus.wvalid}, 2'b01);
      tick();
      chk("w_hold", {bus.wvalid, bus.bready}, 2'b10);
      bus.wready = 1; tick(); bus.wready = 0;
    end else begin
      bus.awready = 1; bus.wready = 1; tick(); bus.awready = 0; bus.wready = 0;
    end
    chk("bready", {bus.bready, bus.awvalid, bus.wvalid}, 3'b100);
    bus.bvalid = 1; bus.bid = 12'h040; tick(); bus.bvalid = 0;
  endtask
  initial begin
    sq_base = 64'h1000; cq_base = 64'h2000;
    rst = 1; clear_in(); tick(); tick();
    chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.cmd_valid, bus.rready, bus.bready,
                       bus.sqdb_ready, bus.cqdb_ready, bus.cpl_ready}, 9'd0);
    chk("rst_ptrs", {sq_head, cq_tail, phase, err}, {32'd0, 1'b1, 1'b0});
    chk("rst_data", {bus.araddr, bus.awaddr, bus.wstrb}, 192'd0);
    rst = 0; tick();
    chk("ready_up", {bus.sqdb_ready, bus.cqdb_ready, bus.cpl_ready}, 3'b111);
    sqdb(16'd3);
    for (int i = 0; i < 3; i++)
      fetch(64'h1000 + 64'(i) * 64, {16{32'hA5000000 | 32'(i)}}, 2'd0, 1'b0, i == 1);
    chk("sq_head3", sq_head, 3);
    tick();
    chk("sq_idle", bus.arvalid, 0);
    post(16'h0055, 15'd0, 1'b0, aa, ws, wd);
    chk("dw2_head", wd[95:64], 32'h00010003);
    do_reset();
    post(16'h0012, 15'd0, 1'b0, aa, ws, wd);
    chk("cqe0_addr", aa, 64'h2000);
    chk("cqe0_strb", ws, 64'h000000000000FFFF);
    chk("cqe0_dw", wd[127:0], {32'h00010012, 32'h00010000, 64'd0});
    chk("cqe0_rest", wd[511:128], 384'd0);
    chk("cq_tail1", {cq_tail, bus.cpl_ready}, {16'd1, 1'b1});
    post(16'h0012, 15'd0, 1'b1, aa, ws, wd);
    chk("cqe1_addr", aa, 64'h2000);
    chk("cqe1_strb", ws, 64'h00000000FFFF0000);
    chk("cqe1_dw3", wd[255:224], 32'h00010012);
    chk("cqe1_lane0", wd[127:0], 128'd0);
    post(16'hBEEF, 15'h4002, 1'b0, aa, ws, wd);
    chk("cqe2_strb", ws, 64'h0000FFFF00000000);
    chk("cqe2_dw3", wd[383:352], 32'h8005BEEF);
    do_reset();
    for (int i = 0; i < 63; i++) post(16'(i), 15'd0, 1'b0, aa, ws, wd);
    chk("full_ptrs", {cq_tail, phase}, {16'd63, 1'b1});
    chk("full_rdy0", bus.cpl_ready, 0);
    tick(); tick();
    chk("full_rdy1", bus.cpl_ready, 0);
    cqdb(16'd1);
    chk("unfull_rdy", bus.cpl_ready, 1);
    cqdb(16'd63);
    post(16'h00AA, 15'd0, 1'b0, aa, ws, wd);
    chk("wrap_addr", aa, 64'h23C0);
    chk("wrap_strb", ws, 64'hFFFF000000000000);
    chk("wrap_dw3", wd[511:480], 32'h000100AA);
    chk("wrap_ptrs", {cq_tail, phase}, {16'd0, 1'b0});
    post(16'h00BB, 15'd0, 1'b0, aa, ws, wd);
    chk("ph0_dw3", wd[127:96], 32'h000000BB);
    chk("ph0_state", {cq_tail, phase}, {16'd1, 1'b0});
    do_reset();
    sqdb(16'd64);
    chk("bad_sqdb_err", err, 1);
    tick(); tick(); tick();
    chk("bad_sqdb_idle", {bus.arvalid, sq_head}, 17'd0);
    do_reset();
    bus.cqdb_valid = 1; bus.cqdb_head = 16'd64;
    sqdb(16'd1);
    bus.cqdb_valid = 0;
    chk("dual_db_err", {err, bus.cpl_ready}, 2'b11);
    fetch(64'h1000, {8{64'h0123456789ABCDEF}}, 2'd0, 1'b0, 1'b0);
    chk("dual_db_head", sq_head, 1);
    do_reset();
    sqdb(16'd2);
    tick();
    chk("mid_arvalid", bus.arvalid, 1);
    rst = 1; tick();
    chk("mid_rst", {bus.arvalid, bus.sqdb_ready, sq_head}, 18'd0);
    rst = 0; tick(); tick(); tick();
    chk("mid_quiet", {bus.arvalid, sq_head, err}, 18'd0);
    sqdb(16'd1);
`ifdef NVME_RESP_RESP_CHECK_EN
    fetch(64'h1000, {16{32'hDEADBEEF}}, 2'd2, 1'b1, 1'b0);
    chk("rresp_err", {err, sq_head}, {1'b1, 16'd1});
    tick();
    chk("rresp_nocmd", {bus.cmd_valid, bus.arvalid}, 2'b00);
`else
    fetch(64'h1000, {16{32'hDEADBEEF}}, 2'd2, 1'b0, 1'b0);
    chk("rresp_ignored", {err, sq_head}, {1'b0, 16'd1});
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
